// File: rtl/program_loader.sv
// program_loader
//
// Write side of the processor's program memory. Accepts a framed byte stream
// over a valid/ready handshake. Each frame has the form:
//   count byte N, then N (high, low) byte pairs, then an XOR checksum byte.
// Each byte pair is assembled into one instruction word and written with a
// single-cycle WE pulse. The processor is held in reset (CPU_HOLD=1) unless
// the most recent load completed with a correct checksum.
//
// Parameters
//   ADDR_WIDTH   program memory address width (depth = 2**ADDR_WIDTH)
//   INSTR_WIDTH  instruction word width; the low 8 bits come from the low
//                byte and the remaining upper bits come from the high byte
//
// Ports
//   CLK       clock; all state changes occur on the rising edge
//   RST       asynchronous, active-high reset
//   START     begins a new load; honoured only in IDLE, DONE or ERROR
//   IN_DATA   stream byte
//   IN_VALID  IN_DATA is valid
//   IN_READY  loader can accept a byte (in COUNT, HI, LO, CHECK)
//   WE        program memory write enable, one-cycle pulse per word
//   WADDR     write address; holds its value after WE drops
//   WDATA     write data; holds its value after WE drops
//   CPU_HOLD  1 = processor held in reset; low only in DONE
//   BUSY      load in progress (COUNT through CHECK)
//   DONE      last load succeeded
//   ERR       last load failed
module program_loader #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned INSTR_WIDTH = 12
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [7:0]             IN_DATA,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic                   WE,
    output logic [ADDR_WIDTH-1:0]  WADDR,
    output logic [INSTR_WIDTH-1:0] WDATA,
    output logic                   CPU_HOLD,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);

    // Bits of the high byte that land in the instruction word.
    localparam int unsigned HiW   = INSTR_WIDTH - 8;
    // Word counter needs one extra bit so that a full memory (N = depth) fits.
    localparam int unsigned CntW  = ADDR_WIDTH + 1;
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [8:0]  DepthB = 9'(Depth);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        count_q, count_d;   // words in the frame
    logic [CntW-1:0]        idx_q, idx_d;       // words assembled so far
    logic [HiW-1:0]         hi_q, hi_d;         // upper instruction bits
    logic [7:0]             xor_q, xor_d;       // running checksum
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;

    logic count_ok;
    logic hi_ok;

    // Count must be in 1..Depth.
    assign count_ok = (IN_DATA != 8'd0) && ({1'b0, IN_DATA} <= DepthB);
    // Any set bit above the bits that fit in the instruction word is an error.
    assign hi_ok    = ((IN_DATA >> HiW) == 8'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            count_q <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            xor_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            xor_q   <= xor_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        xor_d   = xor_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (START) begin
                    state_d = StCount;
                    idx_d   = '0;
                    xor_d   = '0;
                    waddr_d = '0;
                end
            end

            StCount: begin
                if (IN_VALID) begin
                    xor_d = IN_DATA;
                    if (count_ok) begin
                        count_d = IN_DATA[CntW-1:0];
                        state_d = StHi;
                    end else begin
                        state_d = StError;
                    end
                end
            end

            StHi: begin
                if (IN_VALID) begin
                    xor_d = xor_q ^ IN_DATA;
                    if (hi_ok) begin
                        hi_d    = IN_DATA[HiW-1:0];
                        state_d = StLo;
                    end else begin
                        state_d = StError;
                    end
                end
            end

            StLo: begin
                if (IN_VALID) begin
                    xor_d   = xor_q ^ IN_DATA;
                    // Address and data are captured here so they are stable
                    // for the whole WE cycle and persist afterwards.
                    waddr_d = idx_q[ADDR_WIDTH-1:0];
                    wdata_d = {hi_q, IN_DATA};
                    idx_d   = idx_q + 1'b1;
                    state_d = StWrite;
                end
            end

            StWrite: begin
                state_d = (idx_q == count_q) ? StCheck : StHi;
            end

            StCheck: begin
                if (IN_VALID) begin
                    state_d = (IN_DATA == xor_q) ? StDone : StError;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state or taken straight from registers, so
    // nothing depends combinationally on IN_VALID or IN_DATA.
    // ------------------------------------------------------------------
    always_comb begin
        IN_READY = 1'b0;
        WE       = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        ERR      = 1'b0;
        CPU_HOLD = 1'b1;

        unique case (state_q)
            StCount, StHi, StLo, StCheck: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
            end
            StWrite: begin
                WE   = 1'b1;
                BUSY = 1'b1;
            end
            StDone: begin
                DONE     = 1'b1;
                CPU_HOLD = 1'b0;
            end
            StError: begin
                ERR = 1'b1;
            end
            default: ;
        endcase
    end

    assign WADDR = waddr_q;
    assign WDATA = wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. A frame-level model turns each byte
// stream into the list of expected memory writes, the number of bytes the
// loader will consume and the final outcome; a monitor checks every write
// and the output invariants each cycle.
module tb_program_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [7:0]  IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic        WE;
    logic [3:0]  WADDR;
    logic [11:0] WDATA;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    program_loader #(
        .ADDR_WIDTH  (4),
        .INSTR_WIDTH (12)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .WE       (WE),
        .WADDR    (WADDR),
        .WDATA    (WDATA),
        .CPU_HOLD (CPU_HOLD),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];       // {addr, data} of writes still expected
    logic [7:0]  fr[$];          // frame under test
    logic [15:0] m_w[$];         // model: writes
    int          m_used;         // model: bytes consumed
    bit          m_ok;           // model: frame succeeds
    int          hold_start_at;  // byte index from which START is held high
    int unsigned t0;
    int unsigned m_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame model, straight from the frame rules.
    task automatic model();
        logic [7:0] n, x, hi, lo;
        m_w.delete();
        m_ok   = 1'b0;
        n      = fr[0];
        x      = n;
        m_used = 1;
        if (n == 8'd0 || n > 8'd16) return;
        for (int k = 0; k < int'(n); k++) begin
            hi = fr[m_used];
            x ^= hi;
            m_used++;
            if (hi[7:4] != 4'd0) return;
            lo = fr[m_used];
            x ^= lo;
            m_used++;
            m_w.push_back({4'(k), hi[3:0], lo});
        end
        m_ok = (fr[m_used] == x);
        m_used++;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        t0 = cyc;
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        IN_VALID = 1'b0;
        repeat (gap) @(negedge CLK);
        IN_VALID = 1'b1;
        IN_DATA  = b;
        w = 0;
        while (!IN_READY && w < 20) begin
            @(negedge CLK);
            w++;
        end
        if (!IN_READY) begin
            check("ready_timeout", 32'(IN_READY), 32'd1);
            IN_VALID = 1'b0;
            return;
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int gap);
        model();
        foreach (m_w[i]) exp_q.push_back(m_w[i]);
        pulse_start();
        for (int i = 0; i < m_used; i++) begin
            if (i == hold_start_at) START = 1'b1;
            send_byte(fr[i], gap);
        end
        START    = 1'b0;
        m_cycles = cyc - t0;
        check({tag, "_done"}, 32'(DONE), 32'(m_ok));
        check({tag, "_err"}, 32'(ERR), 32'(!m_ok));
        check({tag, "_hold"}, 32'(CPU_HOLD), 32'(!m_ok));
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(IN_READY), 32'd0);
        check({tag, "_we"}, 32'(WE), 32'd0);
        check({tag, "_waddr"}, 32'(WADDR), 32'd0);
        check({tag, "_wdata"}, 32'(WDATA), 32'd0);
        check({tag, "_cpu_hold"}, 32'(CPU_HOLD), 32'd1);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_done"}, 32'(DONE), 32'd0);
        check({tag, "_err"}, 32'(ERR), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST           = 1'b1;
        START         = 1'b0;
        IN_VALID      = 1'b0;
        IN_DATA       = 8'h00;
        hold_start_at = -1;

        // Monitor: every write must be the next expected one.
        fork
            forever begin
                logic [15:0] e;
                @(negedge CLK);
                if (!RST) begin
                    if (WE) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_we", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("waddr", 32'(WADDR), 32'(e[15:12]));
                            check("wdata", 32'(WDATA), 32'(e[11:0]));
                        end
                    end
                    check("hold_vs_done", 32'(CPU_HOLD), 32'(!DONE));
                    check("busy_excl", 32'(BUSY & (DONE | ERR)), 32'd0);
                end
            end
        join_none

        repeat (2) @(negedge CLK);
        check_reset_vals("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Pin the model with hand-computed values.
        fr = {8'h02, 8'h01, 8'h05, 8'h03, 8'hA0, 8'hA5};
        model();
        check("model_w0", 32'(m_w[0]), 32'h0105);
        check("model_w1", 32'(m_w[1]), 32'h13A0);
        check("model_ok", 32'(m_ok), 32'd1);
        fr = {8'h01, 8'h02, 8'h34, 8'h00};
        model();
        check("model_bad_w0", 32'(m_w[0]), 32'h0234);
        check("model_bad_ok", 32'(m_ok), 32'd0);

        // Valid load, back to back; DONE 8 cycles after START.
        fr = {8'h02, 8'h01, 8'h05, 8'h03, 8'hA0, 8'hA5};
        run_frame("valid", 0);
        check("valid_cycles", 32'(m_cycles), 32'd8);
        check("valid_done_lit", 32'(DONE), 32'd1);
        check("valid_hold_lit", 32'(CPU_HOLD), 32'd0);
        check("valid_waddr_hold", 32'(WADDR), 32'h1);
        check("valid_wdata_hold", 32'(WDATA), 32'h3A0);

        // Bad counts.
        fr = {8'h00};
        run_frame("count00", 0);
        check("count00_err_lit", 32'(ERR), 32'd1);
        fr = {8'h11};
        run_frame("count11", 0);

        // Bad high nibble; later bytes must not be accepted.
        fr = {8'h01, 8'h1F};
        run_frame("nibble", 0);
        IN_VALID = 1'b1;
        IN_DATA  = 8'h05;
        repeat (4) begin
            @(negedge CLK);
            check("nibble_not_ready", 32'(IN_READY), 32'd0);
            check("nibble_err_stays", 32'(ERR), 32'd1);
        end
        IN_VALID = 1'b0;

        // Bad checksum, then the same frame with the correct checksum.
        fr = {8'h01, 8'h02, 8'h34, 8'h00};
        run_frame("badsum", 0);
        check("badsum_hold_lit", 32'(CPU_HOLD), 32'd1);
        fr = {8'h01, 8'h02, 8'h34, 8'h37};
        run_frame("goodsum", 0);
        check("goodsum_done_lit", 32'(DONE), 32'd1);

        // Backpressure: IN_VALID low every other cycle.
        fr = {8'h02, 8'h01, 8'h05, 8'h03, 8'hA0, 8'hA5};
        run_frame("bp", 1);

        // START held high mid-frame must be ignored.
        fr = {8'h01, 8'h00, 8'h12, 8'h13};
        hold_start_at = 1;
        run_frame("midstart", 0);
        hold_start_at = -1;

        // START with IN_VALID in DONE: byte is not consumed there.
        exp_q.push_back(16'h0708);
        IN_VALID = 1'b1;
        IN_DATA  = 8'h01;
        START    = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("restart_ready", 32'(IN_READY), 32'd1);
        check("restart_done_clr", 32'(DONE), 32'd0);
        check("restart_busy", 32'(BUSY), 32'd1);
        send_byte(8'h01, 0);
        send_byte(8'h07, 0);
        send_byte(8'h08, 0);
        send_byte(8'h0E, 0);
        check("restart_done", 32'(DONE), 32'd1);
        check("restart_writes_left", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while in LO.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        check("lo_ready", 32'(IN_READY), 32'd1);
        check("lo_busy", 32'(BUSY), 32'd1);
        #2 RST = 1'b1;
        #1 check_reset_vals("async");
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("after_reset_idle_ready", 32'(IN_READY), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that writes instruction words into the processor's 16-entry, 12-bit program memory; it is the write side of the interface the program counter and decoder read from. It accepts a framed byte stream over a valid/ready handshake, assembles each 12-bit instruction from two bytes, and issues one write per word. It holds the processor in reset while a load is in progress. It releases the processor only after a complete frame with a correct checksum.

## Interface
- ADDR_WIDTH, 4: program memory address width; depth is 2**ADDR_WIDTH = 16.
- INSTR_WIDTH, 12: instruction word width; [11:8] opcode, [7:0] immediate.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- START  in  1  begin a new load; sampled only in IDLE, DONE or ERROR.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader can accept a byte; transfer occurs when IN_VALID & IN_READY at the clock edge.
- WE  out  1  program memory write enable; one-cycle pulse per word.
- WADDR  out  ADDR_WIDTH  write address.
- WDATA  out  INSTR_WIDTH  write data.
- CPU_HOLD  out  1  ORed into the program counter RST; 1 = processor held in reset.
- BUSY  out  1  load in progress (states COUNT through CHECK).
- DONE  out  1  last load succeeded.
- ERR  out  1  last load failed.

## Operation
- Frame: count byte N, then N word pairs (high byte, low byte), then checksum byte.
- Count byte: valid range is 1..16. A value of 0 or greater than 16 is an error.
- Word assembly: WDATA = {high[3:0], low[7:0]}. If high[7:4] is nonzero, the frame is an error.
- Checksum: XOR of every preceding byte in the frame, including N.
- States:
  - IDLE: reset state. START moves to COUNT.
  - COUNT: accepts N. A valid N moves to HI. An invalid N moves to ERROR.
  - HI: accepts the high byte. Bad upper nibble moves to ERROR; otherwise moves to LO.
  - LO: accepts the low byte, then moves to WRITE.
  - WRITE: WE=1 for exactly one cycle. Moves to HI if words remain, otherwise to CHECK.
  - CHECK: accepts the checksum byte. A match moves to DONE; a mismatch moves to ERROR.
  - DONE and ERROR: terminal until START, which moves to COUNT.
- Entering COUNT clears the word address to 0, clears the running XOR to 0, and clears DONE and ERR.
- Word k is written to address k, for k = 0..N-1. Addresses N..15 are never written; there is no wrap-around.
- IN_READY=1 only in COUNT, HI, LO and CHECK.
- START is ignored in COUNT, HI, LO, WRITE and CHECK. A load cannot be restarted mid-frame except by RST.
- Writes already issued before an error are not undone. The processor stays held in reset, so they are never executed.
- CPU_HOLD=0 only in DONE.

## Timing
- Reset values: state IDLE, IN_READY=0, WE=0, WADDR=0, WDATA=0, CPU_HOLD=1, BUSY=0, DONE=0, ERR=0.
- RST asserted mid-load: all outputs return to reset values immediately, without waiting for a clock edge; any in-flight write is dropped.
- All outputs are registered or decoded from state only; there is no combinational path from IN_VALID or IN_DATA to any output.
- START high at edge t: state is COUNT and IN_READY=1 from t+1.
- Byte latency: a low byte accepted at edge t produces WE=1 with stable WADDR/WDATA during cycle t+1. IN_READY=0 during that cycle.
- Minimum frame time with IN_VALID held high: 1 + 3N + 1 cycles after START. For N=2, that is 8 cycles.
- IN_VALID gaps stall the current state indefinitely; there is no timeout.
- WADDR and WDATA hold their last written values after WE drops.
- DONE, ERR and CPU_HOLD change on the same edge that moves the state into DONE or ERROR.
- START and IN_VALID both high in DONE: START wins, and the byte is not consumed because IN_READY=0.

## Test plan
- Valid load: after RST, START, then bytes 02, 01, 05, 03, A0, A5 -> WE pulses with addr0=0x105 and addr1=0x3A0. DONE=1, CPU_HOLD=0 exactly 8 cycles after START.
- Bad count: START, then byte 00 -> ERR=1, CPU_HOLD=1, no WE. Repeat with byte 11 -> same result.
- Bad high nibble: START, then bytes 01, 1F -> ERR=1 with no WE. Subsequent IN_VALID is ignored because IN_READY=0.
- Bad checksum: START, then bytes 01, 02, 34, 00 -> addr0=0x234 is written, then ERR=1 and CPU_HOLD remains 1. A new START followed by a correct frame with checksum 37 leads to DONE=1.
- Backpressure: the valid-load stream with IN_VALID toggling every other cycle -> identical writes and DONE; no byte is lost or duplicated.
- Async reset: assert RST between edges while in LO -> all outputs at reset values before the next edge, CPU_HOLD=1. START during BUSY has no effect.
